// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizer + debounce FSM producing press/release/long-press pulses
module button_debouncer #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_PRESS_CYCLES);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    CHECK_PRESS,
    PRESSED,
    CHECK_RELEASE
  } state_t;

  state_t state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic p, s;
  logic btn_d, press_d, release_d, long_d;

  // Normalize so that 1 always means pressed; the released level is then 0.
  assign p = btn_in ^ (ACTIVE_LOW != 0);
  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      state         <= RELEASED;
      dcnt          <= '0;
      lcnt          <= '0;
      btn_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], p};
      state         <= state_n;
      dcnt          <= dcnt_n;
      lcnt          <= lcnt_n;
      btn_state     <= btn_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
    end
  end

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    lcnt_n  = lcnt;
    unique case (state)
      RELEASED: begin
        if (s) begin
          state_n = CHECK_PRESS;
          dcnt_n  = DW'(1);
        end else begin
          dcnt_n  = '0;
        end
      end
      CHECK_PRESS: begin
        if (!s) begin
          state_n = RELEASED;
          dcnt_n  = '0;
        end else if (dcnt == D_LAST) begin
          state_n = PRESSED;
          dcnt_n  = '0;
          lcnt_n  = '0;
        end else begin
          dcnt_n  = dcnt + DW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n = CHECK_RELEASE;
          dcnt_n  = DW'(1);
        end else if (lcnt < L_MAX) begin
          lcnt_n  = lcnt + LW'(1);
        end
      end
      CHECK_RELEASE: begin
        // A return to pressed here is a bounce; the hold count is kept.
        if (s) begin
          state_n = PRESSED;
          dcnt_n  = '0;
        end else if (dcnt == D_LAST) begin
          state_n = RELEASED;
          dcnt_n  = '0;
          lcnt_n  = '0;
        end else begin
          dcnt_n  = dcnt + DW'(1);
        end
      end
      default: begin
        state_n = RELEASED;
        dcnt_n  = '0;
        lcnt_n  = '0;
      end
    endcase
  end

  always_comb begin
    btn_d     = (state_n == PRESSED) || (state_n == CHECK_RELEASE);
    press_d   = (state == CHECK_PRESS) && s && (dcnt == D_LAST);
    release_d = (state == CHECK_RELEASE) && !s && (dcnt == D_LAST);
    long_d    = (state == PRESSED) && s && (lcnt == L_LAST);
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer (2 sync, 8 debounce, 20 long)
module tb_button_debouncer;

  localparam logic [2:0] EV_PRESS   = 3'b001;
  localparam logic [2:0] EV_RELEASE = 3'b010;
  localparam logic [2:0] EV_LONG    = 3'b100;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_state, press_pulse, release_pulse, long_pulse;

  ev_t sbq[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  logic exp_btn = 1'b0;

  button_debouncer #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8),
    .LONG_PRESS_CYCLES(20),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_state(btn_state),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int at, input logic [2:0] kind);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    sbq.push_back(e);
  endtask

  // Monitor: samples registered outputs 1 time unit after each rising edge.
  initial begin
    logic [2:0] act, exp_vec;
    forever begin
      @(posedge clk);
      #1;
      act = {long_pulse, release_pulse, press_pulse};
      exp_vec = 3'b000;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        errors++;
        $display("FAIL missed_event cyc=%0d kind=%b expected_at=%0d", cyc, sbq[0].kind, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (rst) begin
        exp_btn = 1'b0;
      end else if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_vec = sbq[0].kind;
        if (exp_vec == EV_PRESS)   exp_btn = 1'b1;
        if (exp_vec == EV_RELEASE) exp_btn = 1'b0;
        void'(sbq.pop_front());
      end
      checks++;
      if (act !== exp_vec) begin
        errors++;
        $display("FAIL pulses cyc=%0d got {long,rel,press}=%b want %b", cyc, act, exp_vec);
      end
      checks++;
      if (btn_state !== exp_btn) begin
        errors++;
        $display("FAIL btn_state cyc=%0d got %b want %b", cyc, btn_state, exp_btn);
      end
    end
  end

  initial begin
    int p;
    // Reset held 3 cycles with the button already pressed.
    rst    = 1'b1;
    btn_in = 1'b0;
    step(3);
    rst = 1'b0;
    expect_ev(cyc + 10, EV_PRESS);
    expect_ev(cyc + 30, EV_LONG);
    step(32);
    btn_in = 1'b1;
    expect_ev(cyc + 10, EV_RELEASE);
    step(20);

    // Clean press held 30 cycles.
    btn_in = 1'b0;
    expect_ev(cyc + 10, EV_PRESS);
    expect_ev(cyc + 30, EV_LONG);
    step(30);
    btn_in = 1'b1;
    expect_ev(cyc + 10, EV_RELEASE);
    step(20);

    // Bounce every 3 cycles, then settle pressed.
    for (int i = 0; i < 14; i++) begin
      btn_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(3);
    end
    btn_in = 1'b0;
    expect_ev(cyc + 10, EV_PRESS);
    step(12);
    btn_in = 1'b1;
    expect_ev(cyc + 10, EV_RELEASE);
    step(20);

    // Threshold: 7 low cycles rejected, 8 accepted.
    btn_in = 1'b0;
    step(7);
    btn_in = 1'b1;
    step(20);
    btn_in = 1'b0;
    expect_ev(cyc + 10, EV_PRESS);
    step(8);
    btn_in = 1'b1;
    expect_ev(cyc + 10, EV_RELEASE);
    step(20);

    // Release bounce of 4 cycles while held; hold count resumes.
    btn_in = 1'b0;
    p = cyc + 10;
    expect_ev(p, EV_PRESS);
    step(25);
    btn_in = 1'b1;
    step(4);
    btn_in = 1'b0;
    expect_ev(p + 25, EV_LONG);
    step(15);
    btn_in = 1'b1;
    expect_ev(cyc + 10, EV_RELEASE);
    step(20);

    // Reset during CHECK_PRESS (dcnt=5), then during PRESSED (lcnt=12).
    btn_in = 1'b0;
    step(7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_ev(cyc + 10, EV_PRESS);
    step(22);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    btn_in = 1'b1;
    step(40);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL queue_drained got %0d pending want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
